seq_addsub_unit: RTL

Multi-cycle parametrised adder/subtractor. Operands are captured through a valid/ready handshake, then processed CHUNK bits per clock by an internal ripple chunk adder, with the carry held in a register between chunks. Add or subtract is selected per transaction, not at elaboration. The result, carry/borrow and signed-overflow flag are returned on a valid/ready output handshake. This unit replaces the full-width combinational ripple add/sub wherever WIDTH is too wide to close timing in one cycle.

---
 rtl/addsub_pkg.sv | 31 +++
 rtl/addsub_chunk.sv | 23 ++
 rtl/seq_addsub_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the sequential adder/subtractor.
// Provides the FSM state type, mode encodings and the signed-limit helper used by saturation.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  localparam int LIMIT_W = 256;

  // Returns the signed maximum (want_min=0) or minimum (want_min=1) of a
  // width-bit two's-complement number, zero-extended to LIMIT_W bits.
  function automatic logic [LIMIT_W-1:0] signed_limit(input int width, input logic want_min);
    logic [LIMIT_W-1:0] v;
    v = '0;
    for (int i = 0; i < LIMIT_W; i++) begin
      if (i < width - 1) begin
        v[i] = ~want_min;
      end else if (i == width - 1) begin
        v[i] = want_min;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit combinational ripple-carry adder built from generated full-adder cells.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/seq_addsub_unit.sv
// Multi-cycle add/subtract: processes CHUNK bits per clock with a registered carry between chunks.
// Optional ADDSUB_SAT_EN clamps the result to the signed max/min on overflow.
module seq_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

`ifdef ADDSUB_SAT_EN
  localparam logic [LIMIT_W-1:0] SAT_MAX_FULL = signed_limit(WIDTH, 1'b0);
  localparam logic [LIMIT_W-1:0] SAT_MIN_FULL = signed_limit(WIDTH, 1'b1);
  localparam logic [WIDTH-1:0]   SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]   SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];
`endif

  state_e state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, result_reg;
  logic             carry_reg, carry_out_reg, overflow_reg;
  logic [IDXW-1:0]  idx;

  logic [CHUNK-1:0] chunk_x, chunk_y, chunk_s;
  logic             chunk_co;
  logic             accept, ovf_final;

  assign chunk_x = a_reg[int'(idx)*CHUNK +: CHUNK];
  assign chunk_y = b_reg[int'(idx)*CHUNK +: CHUNK];

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x  (chunk_x),
    .y  (chunk_y),
    .ci (carry_reg),
    .s  (chunk_s),
    .co (chunk_co)
  );

  assign accept = (state == IDLE) && in_valid;

  // The final chunk carries the result MSB, so overflow is decided from its sum bit.
  assign ovf_final = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                     (chunk_s[CHUNK-1] != a_reg[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)          state_next = CALC;
      CALC:    if (idx == LAST_IDX)   state_next = DONE;
      DONE:    if (out_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      idx           <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= (mode == MODE_ADD) ? b : ~b;
      carry_reg <= cin;
      idx       <= '0;
    end else if (state == CALC) begin
      result_reg[int'(idx)*CHUNK +: CHUNK] <= chunk_s;
      carry_reg <= chunk_co;
      if (idx == LAST_IDX) begin
        carry_out_reg <= chunk_co;
        overflow_reg  <= ovf_final;
`ifdef ADDSUB_SAT_EN
        if (ovf_final) begin
          result_reg <= a_reg[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
`endif
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_reg;
  assign carry_out = carry_out_reg;
  assign overflow  = overflow_reg;

endmodule
